// File: rtl/icache_pkg.sv
// Shared definitions between icache_dm and its refill controller.
package icache_pkg;

  localparam int ICACHE_ADDR_W = 32;
  localparam int ICACHE_DATA_W = 32;

  // Returned in place of real data when a refill is abandoned.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP,
    GAP
  } refill_state_t;

endpackage

// File: rtl/refill_sat_counter.sv
// Generic saturating up-counter with enable; sticks at all-ones.
module refill_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss service: one outstanding read on the instruction bus, word returned with a 1-cycle iready pulse.
// Optional WAIT-state abort with NOP return and err pulse under `define REFILL_TIMEOUT_EN.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W  = ICACHE_ADDR_W,
  parameter int DATA_W  = ICACHE_DATA_W,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss,
  input  logic [ADDR_W-1:0] fetchaddr,
  output logic [DATA_W-1:0] ifetch,
  output logic              iready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  refill_cnt,
  output logic              err
);

  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("TIMEOUT must be at least 2");
  end

  refill_state_t state;
  logic          cnt_en;

`ifdef REFILL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign err = err_q;
  // An aborted refill still passes through RESP but must not count.
  assign cnt_en = (state == RESP) && !err_q;
`else
  assign err    = 1'b0;
  assign cnt_en = (state == RESP);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ifetch   <= '0;
      iready   <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
`ifdef REFILL_TIMEOUT_EN
      tmo_cnt  <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      iready <= 1'b0;
`ifdef REFILL_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (miss) begin
            mem_addr <= fetchaddr;
            mem_req  <= 1'b1;
            busy     <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_rvalid) begin
              ifetch <= mem_rdata;
              iready <= 1'b1;
              state  <= RESP;
            end else begin
`ifdef REFILL_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            ifetch <= mem_rdata;
            iready <= 1'b1;
            state  <= RESP;
          end
`ifdef REFILL_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            ifetch <= DATA_W'(NOP_INSTR);
            iready <= 1'b1;
            err_q  <= 1'b1;
            state  <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        RESP: begin
          state <= GAP;
        end
        GAP: begin
          // Miss is ignored here so the cache has a cycle to drop it.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  refill_sat_counter #(
    .CNT_W (CNT_W)
  ) u_refill_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .cnt   (refill_cnt)
  );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized self-checking bench for icache_refill_ctrl against a latency/count/data scoreboard.
module tb_icache_refill_ctrl;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 6;
  localparam int TIMEOUT = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              miss = 1'b0;
  logic [ADDR_W-1:0] fetchaddr = '0;
  logic [DATA_W-1:0] ifetch;
  logic              iready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy;
  logic [CNT_W-1:0]  refill_cnt;
  logic              err;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [DATA_W-1:0] exp_ifetch = '0;

  always #5 clk = ~clk;

  icache_refill_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .miss       (miss),
    .fetchaddr  (fetchaddr),
    .ifetch     (ifetch),
    .iready     (iready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .refill_cnt (refill_cnt),
    .err        (err)
  );

  // One refill: bus grants after g cycles of mem_req, data r cycles after the grant.
  // Expected iready cycle (counted from driving miss) is 2+g+r.
  task automatic run_refill(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] new_addr,
                            input int g, input int r, input logic [DATA_W-1:0] data,
                            input bit keep_miss);
    int cyc, req_seen, rv_wait, pulses, exp_lat;
    bit granted, delivered, done;
    exp_lat = 2 + g + r;
    cyc = 0; req_seen = 0; rv_wait = 0; pulses = 0;
    granted = 0; delivered = 0; done = 0;
    miss = 1'b1;
    fetchaddr = addr;
    while (!done && cyc < exp_lat + 8) begin
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
      if (mem_req && !granted) begin
        checks++;
        if (mem_addr !== addr)
          $display("FAIL mem_addr: got %h expected %h", mem_addr, addr);
        if (mem_addr !== addr) errors++;
        fetchaddr = new_addr;
        if (req_seen == g) begin
          mem_gnt = 1'b1;
          granted = 1;
          if (r == 0) begin
            mem_rvalid = 1'b1; mem_rdata = data; delivered = 1;
          end
        end
        req_seen++;
      end else if (granted && !delivered) begin
        rv_wait++;
        if (rv_wait == r) begin
          mem_rvalid = 1'b1; mem_rdata = data; delivered = 1;
        end
      end
      @(posedge clk); #1;
      cyc++;
      checks++;
      if (err !== 1'b0) begin
        errors++; $display("FAIL err_normal: got %b expected 0 at cycle %0d", err, cyc);
      end
      if (iready === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          exp_cnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX;
          exp_ifetch = data;
          checks++;
          if (cyc != exp_lat) begin
            errors++; $display("FAIL iready_latency: got %0d expected %0d", cyc, exp_lat);
          end
          checks++;
          if (ifetch !== data) begin
            errors++; $display("FAIL ifetch: got %h expected %h", ifetch, data);
          end
        end
        if (!keep_miss) miss = 1'b0;
      end
      if (pulses > 0 && busy === 1'b0) done = 1;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL refill_timeout: got pulses=%0d busy=%b expected completion", pulses, busy);
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL iready_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (refill_cnt !== CNT_W'(exp_cnt)) begin
      errors++; $display("FAIL refill_cnt: got %0d expected %0d", refill_cnt, exp_cnt);
    end
    checks++;
    if (ifetch !== exp_ifetch) begin
      errors++; $display("FAIL ifetch_hold: got %h expected %h", ifetch, exp_ifetch);
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({ifetch, iready, mem_req, mem_addr, busy, refill_cnt, err} !== '0) begin
      errors++;
      $display("FAIL %s: got ifetch=%h iready=%b req=%b addr=%h busy=%b cnt=%0d err=%b expected all 0",
               tag, ifetch, iready, mem_req, mem_addr, busy, refill_cnt, err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; miss = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1;
    fetchaddr = 32'h08; mem_rdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    miss = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    exp_cnt = 0; exp_ifetch = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_min_latency();
    run_refill(32'h08, 32'h08, 0, 0, 32'h1000_0000, 0);
  endtask

  task automatic test_stalled_bus();
    run_refill(32'h09, 32'h0C, 3, 5, 32'h1000_0002, 0);
  endtask

  task automatic test_back_to_back();
    run_refill(32'h0A, 32'h0A, 0, 0, 32'h2000_0001, 1);
    run_refill(32'h0E, 32'h0E, 1, 2, 32'h2000_0002, 0);
  endtask

  task automatic test_reset_mid_refill();
    int n;
    miss = 1'b1; fetchaddr = 32'h40;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL midreset_req: got %b expected 1", mem_req);
    end
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0; miss = 1'b0;
    exp_cnt = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_async: got req=%b busy=%b expected 0 0", mem_req, busy);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    n = 0;
    repeat (5) begin
      if (iready === 1'b1) n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL midreset_late_rvalid: got %0d iready pulses expected 0", n);
    end
    exp_ifetch = '0;
    check_all_zero("midreset_idle");
  endtask

  task automatic test_random_saturation();
    for (int i = 0; i < CNT_MAX + 6; i++) begin
      run_refill($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 4),
                 $urandom, 1'($urandom_range(0, 1)));
    end
    checks++;
    if (refill_cnt !== CNT_W'(CNT_MAX)) begin
      errors++; $display("FAIL saturation: got %0d expected %0d", refill_cnt, CNT_MAX);
    end
  endtask

  task automatic test_timeout();
    int n, since_wait;
    bit seen_err;
    miss = 1'b1; fetchaddr = 32'h80;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    since_wait = 0;
    seen_err = 0;
`ifdef REFILL_TIMEOUT_EN
    while (iready !== 1'b1 && since_wait < 3 * TIMEOUT) begin
      mem_rdata = $urandom;
      @(posedge clk); #1; since_wait++;
    end
    miss = 1'b0;
    checks++;
    if (since_wait != TIMEOUT) begin
      errors++; $display("FAIL timeout_latency: got %0d expected %0d", since_wait, TIMEOUT);
    end
    checks++;
    if (err !== 1'b1 || ifetch !== 32'h0000_0013) begin
      errors++; $display("FAIL timeout_nop: got err=%b ifetch=%h expected 1 00000013", err, ifetch);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (refill_cnt !== CNT_W'(exp_cnt) || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL timeout_after: got cnt=%0d busy=%b err=%b expected %0d 0 0",
                         refill_cnt, busy, err, exp_cnt);
    end
`else
    repeat (10 * TIMEOUT) begin
      if (err !== 1'b0) seen_err = 1;
      @(posedge clk); #1; since_wait++;
    end
    checks++;
    if (busy !== 1'b1 || iready !== 1'b0 || seen_err) begin
      errors++; $display("FAIL wait_forever: got busy=%b iready=%b err_seen=%b expected 1 0 0",
                         busy, iready, seen_err);
    end
    checks++;
    if (refill_cnt !== CNT_W'(exp_cnt)) begin
      errors++; $display("FAIL wait_cnt: got %0d expected %0d", refill_cnt, exp_cnt);
    end
    miss = 1'b0;
    reset = 1'b0;
    #1;
    reset = 1'b1;
`endif
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_stalled_bus();
    test_back_to_back();
    test_reset_mid_refill();
    test_random_saturation();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
